// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side constants and the {pc, instruction} entry carried by the prefetch FIFO.
package fetch_queue_pkg;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word-aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instruction} entries with flush; full/empty come from count.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch sequencer: owns fetch_pc, fills the prefetch FIFO, flushes on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_en,
  output logic [31:0]   imem_pc,
  input  logic [31:0]   imem_instruction,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic         push;
  logic         pop;
  logic [31:0]  fetch_pc;
  fetch_entry_t wdata;
  fetch_entry_t head;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full queue still accepts a push when the head leaves this cycle.
  assign push      = fetch_en & ~redirect & ((count < FULL) | pop);

  always_ff @(posedge clk) begin
    if (reset)         fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= align_pc(redirect_pc);
    else if (push)     fetch_pc <= fetch_pc + PC_STEP;
  end

  assign imem_pc    = fetch_pc;
  assign wdata.pc   = fetch_pc;
  assign wdata.inst = imem_instruction;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign out_pc   = out_valid ? head.pc   : 32'h0;
  assign out_inst = out_valid ? head.inst : NOP;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: fetched entries are queued as expected output and checked at the head.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic [31:0]   imem_pc;
  logic [31:0]   imem_instruction;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [CW-1:0] count;
  logic [31:0]   mem_key;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  bit          m_known = 1'b0;
  int          n_chk   = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  // Memory model: word = address ^ key, so the key can tell entries fetched in different phases apart.
  assign imem_instruction = imem_pc ^ mem_key;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_en         (fetch_en),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_inst         (out_inst),
    .count            (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One clock: compare DUT against the scoreboard mid-cycle, advance the model, then cross the edge.
  task automatic step();
    bit   m_pop;
    bit   m_push;
    exp_t e;
    #3;
    if (m_known) begin
      chk("imem_pc", imem_pc, m_pc);
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_inst", out_inst, exp_q[0].inst);
      end else begin
        chk("out_pc_empty", out_pc, 32'h0);
        chk("out_inst_empty", out_inst, 32'h0);
      end
    end
    m_pop  = (exp_q.size() != 0) && out_ready;
    m_push = fetch_en && !redirect && ((exp_q.size() < DEPTH) || m_pop);
    if (reset) begin
      exp_q.delete();
      m_pc    = 32'h0;
      m_known = 1'b1;
    end else if (redirect) begin
      exp_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        e.pc   = m_pc;
        e.inst = m_pc ^ mem_key;
        exp_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; mem_key = 32'h0;
    step(); step();
    reset = 1'b0;
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    // Fill until full with the consumer stalled.
    fetch_en = 1'b1;
    repeat (6) step();
    chk("fill_imem_pc", imem_pc, 32'd16);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_out_pc", out_pc, 32'h0);
    chk("fill_out_inst", out_inst, 32'h0);

    // Full-rate streaming: push and pop together every cycle.
    mem_key = 32'h1234_0000; out_ready = 1'b1;
    repeat (8) step();
    chk("stream_count", 32'(count), 32'd4);
    chk("stream_out_pc", out_pc, 32'd32);

    // Drop to 3 entries, then redirect to an unaligned target.
    fetch_en = 1'b0;
    step();
    chk("pre_redir_count", 32'(count), 32'd3);
    fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_imem_pc", imem_pc, 32'h100);
    step();
    chk("redir_out_pc", out_pc, 32'h100);
    chk("redir_out_inst", out_inst, 32'h100 ^ 32'h1234_0000);

    // Reset wins over a simultaneous redirect.
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    reset = 1'b0; redirect = 1'b0;
    chk("rst_redir_imem_pc", imem_pc, 32'h0);
    chk("rst_redir_count", 32'(count), 32'd0);

    // Queue two entries, then drain them with fetch disabled.
    mem_key = 32'h0; out_ready = 1'b0; fetch_en = 1'b1;
    step(); step();
    chk("hold_count", 32'(count), 32'd2);
    fetch_en = 1'b0; out_ready = 1'b1;
    chk("hold_pop0", out_pc, 32'h0);
    step();
    chk("hold_pop1", out_pc, 32'h4);
    step();
    chk("hold_empty", 32'(out_valid), 32'd0);
    chk("hold_imem_pc", imem_pc, 32'h8);
    step();
    chk("hold_imem_pc2", imem_pc, 32'h8);

    // Wrap of fetch_pc at the top of the address space.
    fetch_en = 1'b1; out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_count1", 32'(count), 32'd1);
    chk("wrap_imem_pc", imem_pc, 32'h0);
    step();
    chk("wrap_count2", 32'(count), 32'd2);
    out_ready = 1'b1;
    step();
    chk("wrap_next_pc", out_pc, 32'h0);
    chk("wrap_count3", 32'(count), 32'd2);

    // Redirect still applies while fetch is disabled.
    fetch_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h41;
    step();
    redirect = 1'b0;
    chk("redir_noen_pc", imem_pc, 32'h40);
    chk("redir_noen_count", 32'(count), 32'd0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 80; i++) begin
      fetch_en    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 7) == 0) mem_key = $urandom;
      step();
    end
    redirect = 1'b0; fetch_en = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("final_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch sequencer that owns the program counter driving the instruction memory's combinational read port. Every cycle it presents a word-aligned PC, captures the returned instruction and pushes the {pc, instruction} pair into a small prefetch FIFO. The decode stage drains the FIFO through a valid/ready handshake. A redirect (branch, jump or exception target) flushes all prefetched entries and restarts fetch at the new PC.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
RESET_PC, 32'h0000_0000, first fetch address after reset; word-aligned.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  synchronous, active-high reset.
fetch_en  input  1  1 = fetching allowed; 0 = hold fetch_pc, no pushes.
imem_pc  output  32  address to instruction memory; equals fetch_pc register.
imem_instruction  input  32  instruction word returned combinationally for imem_pc.
redirect  input  1  flush the queue and restart fetch at redirect_pc.
redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
out_valid  output  1  head entry valid; equals (count != 0).
out_ready  input  1  consumer accepts the head entry this cycle.
out_pc  output  32  PC of the head entry; 0 when empty.
out_inst  output  32  instruction of the head entry; 0 when empty.
count  output  $clog2(DEPTH+1)  current occupancy, for debug and stall logic.

Behaviour:
- Reset is synchronous, active-high; fetch_pc, pointers and count all clear on the same edge.
  - fetch_pc <= RESET_PC; read pointer, write pointer and count <= 0.
  - Outputs after reset: imem_pc = RESET_PC, out_valid = 0, out_pc = 0, out_inst = 0, count = 0.
  - Reset asserted mid-stream discards all entries; it has priority over redirect.
- pop = out_valid & out_ready.
- push = fetch_en & !redirect & ((count < DEPTH) | pop).
  - When full, a push is allowed in the same cycle as a pop. This is a combinational dependency on out_ready, and it sustains 1 instruction/cycle.
- On push:
  - The entry {imem_pc, imem_instruction} is written at the write pointer.
  - fetch_pc <= fetch_pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- On pop: the read pointer advances.
- count update:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop together: count unchanged.
- Both pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are derived from count, never from pointer equality.
- Fetch latency: an instruction at PC P, fetched in cycle n, is visible at out_* from cycle n+1 when the queue was empty. There is no combinational path from imem_instruction to out_*.
- Redirect has priority over every other event except reset:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; pointers and count <= 0; no push that cycle.
  - A pop handshake in the redirect cycle is legal. The consumer may treat that entry as consumed, but it is also discarded by the flush.
  - In the cycle after a redirect: out_valid = 0 and imem_pc = the new target. The first new entry appears one cycle after that.
- fetch_en = 0: fetch_pc and FIFO contents hold; pops continue normally. Redirect still takes effect while fetch_en = 0.
- out_pc and out_inst come from the head-entry storage, muxed to 0 when empty.
  - They are stable while out_valid & !out_ready.
  - Consumers must not depend on them while out_valid = 0.
- No other state machine: the controller is the fetch_pc register plus FIFO control.

Decomposition:
- Shared ISA.v additions:
  - `WORD range macro (existing).
  - `PC_STEP (4).
  - `RESET_PC default value.
  - `NOP encoding (32'h0), for consumers that bubble.
- One natural sub-module: fetch_fifo.
  - Synchronous FIFO, DEPTH x 64 bits.
  - Ports: push/pop/flush, head data, count.
- fetch_queue itself holds fetch_pc, the push/pop/redirect priority logic, and the output muxing.

Test Plan:
- Reset, then fetch_en = 1, out_ready = 0 with memory words = address:
  - imem_pc steps 0, 4, 8, 12 and then holds at 16.
  - count reaches 4; out_pc = 0, out_inst = 0x0.
- From a full queue, out_ready = 1 continuously:
  - out_pc sequence 0, 4, 8, ... one per cycle, with no bubble.
  - count stays 4, because push and pop occur in the same cycle.
- Redirect to 0x00000103 with 3 entries queued and out_ready = 1:
  - Next cycle: count = 0, out_valid = 0, imem_pc = 0x100.
  - The cycle after: out_pc = 0x100.
- Redirect in the same cycle as reset: after the edge, imem_pc = RESET_PC and count = 0.
- fetch_en = 0 with 2 entries queued and out_ready = 1:
  - Two pops: out_pc = 0x0, then 0x4.
  - Then out_valid = 0 while imem_pc holds at 0x8.
- Redirect to 0xFFFFFFFC with fetch_en = 1:
  - Entries with PC 0xFFFFFFFC, then 0x0.
  - No X values; count increments correctly.
